// File: rtl/staff_voice_if.sv
// Key-event handshake between the event source (master) and the staff voice allocator (slave).
interface staff_voice_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_release;

  modport master (output ev_valid, output ev_code, output ev_release, input ev_ready);
  modport slave  (input ev_valid, input ev_code, input ev_release, output ev_ready);
endinterface

// File: rtl/staff_voice_allocator.sv
// Four-voice key allocator feeding the staff tone mapper: press/release/retrigger, auto-release, overflow.
// Define STAFF_VOICE_STEAL_EN to steal the oldest voice on overflow instead of dropping the press.
module staff_voice_allocator #(
  parameter int unsigned HOLD_CYCLES = 25000000,
  parameter int unsigned TIMER_W     = 25
) (
  input  logic                clk,
  input  logic                rst_n,
  staff_voice_if.slave        ev,
  input  logic                all_off,
  output logic [7:0]          scan_code1,
  output logic [7:0]          scan_code2,
  output logic [7:0]          scan_code3,
  output logic [7:0]          scan_code4,
  output logic [3:0]          busy,
  output logic                drop
);

  localparam int unsigned NUM_VOICES = 4;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned CODE_W     = 8;
  localparam logic [TIMER_W-1:0] AGE_LAST =
    (HOLD_CYCLES == 0) ? '1 : TIMER_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEARCH, APPLY} state_t;

  state_t              state, state_next;
  logic [CODE_W-1:0]   voice_code [NUM_VOICES];
  logic [TIMER_W-1:0]  voice_age  [NUM_VOICES];
  logic [CODE_W-1:0]   ev_code_q;
  logic                ev_release_q;
  logic                match_hit, free_hit, match_hit_c, free_hit_c;
  logic [IDX_W-1:0]    match_idx, free_idx, match_idx_c, free_idx_c;
`ifdef STAFF_VOICE_STEAL_EN
  logic [IDX_W-1:0]    oldest_idx, oldest_idx_c;
`endif
  logic                accept_c, wr_en_c, drop_set_c;
  logic [IDX_W-1:0]    wr_idx_c;
  logic [CODE_W-1:0]   wr_code_c;
  logic [NUM_VOICES-1:0] timeout_c;

  assign ev.ev_ready = (state == IDLE);
  assign scan_code1  = voice_code[0];
  assign scan_code2  = voice_code[1];
  assign scan_code3  = voice_code[2];
  assign scan_code4  = voice_code[3];

  always_comb begin
    for (int i = 0; i < int'(NUM_VOICES); i++) begin
      busy[i]      = (voice_code[i] != '0);
      timeout_c[i] = (HOLD_CYCLES != 0) && busy[i] && (voice_age[i] == AGE_LAST);
    end
  end

  // Voice search on the latched code; descending scan so the lowest index wins.
  always_comb begin
    match_hit_c = 1'b0;
    match_idx_c = '0;
    free_hit_c  = 1'b0;
    free_idx_c  = '0;
    for (int i = int'(NUM_VOICES) - 1; i >= 0; i--) begin
      if (voice_code[i] == ev_code_q) begin
        match_hit_c = 1'b1;
        match_idx_c = IDX_W'(i);
      end
      if (voice_code[i] == '0) begin
        free_hit_c = 1'b1;
        free_idx_c = IDX_W'(i);
      end
    end
  end

`ifdef STAFF_VOICE_STEAL_EN
  // Largest age wins; strict compare keeps ties on the lowest index.
  always_comb begin
    oldest_idx_c = '0;
    for (int i = 1; i < int'(NUM_VOICES); i++) begin
      if (voice_age[i] > voice_age[oldest_idx_c]) oldest_idx_c = IDX_W'(i);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else if (all_off) state <= IDLE;
    else state <= state_next;
  end

  // Next state plus the single voice write decided in APPLY.
  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    wr_en_c    = 1'b0;
    wr_idx_c   = '0;
    wr_code_c  = '0;
    drop_set_c = 1'b0;
    case (state)
      IDLE: begin
        if (ev.ev_valid) begin
          accept_c   = 1'b1;
          state_next = SEARCH;
        end
      end
      SEARCH: state_next = APPLY;
      APPLY: begin
        state_next = IDLE;
        if (ev_code_q != '0) begin
          if (ev_release_q) begin
            if (match_hit) begin
              wr_en_c  = 1'b1;
              wr_idx_c = match_idx;
            end
          end else if (match_hit) begin
            wr_en_c   = 1'b1;
            wr_idx_c  = match_idx;
            wr_code_c = ev_code_q;
          end else if (free_hit) begin
            wr_en_c   = 1'b1;
            wr_idx_c  = free_idx;
            wr_code_c = ev_code_q;
          end else begin
`ifdef STAFF_VOICE_STEAL_EN
            wr_en_c   = 1'b1;
            wr_idx_c  = oldest_idx;
            wr_code_c = ev_code_q;
`else
            drop_set_c = 1'b1;
`endif
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_code_q    <= '0;
      ev_release_q <= 1'b0;
      match_hit    <= 1'b0;
      match_idx    <= '0;
      free_hit     <= 1'b0;
      free_idx     <= '0;
`ifdef STAFF_VOICE_STEAL_EN
      oldest_idx   <= '0;
`endif
    end else begin
      if (accept_c) begin
        ev_code_q    <= ev.ev_code;
        ev_release_q <= ev.ev_release;
      end
      if (state == SEARCH) begin
        match_hit  <= match_hit_c;
        match_idx  <= match_idx_c;
        free_hit   <= free_hit_c;
        free_idx   <= free_idx_c;
`ifdef STAFF_VOICE_STEAL_EN
        oldest_idx <= oldest_idx_c;
`endif
      end
    end
  end

  // Voice state: aging and timeouts first, so an APPLY write to the same voice wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_VOICES); i++) begin
        voice_code[i] <= '0;
        voice_age[i]  <= '0;
      end
      drop <= 1'b0;
    end else if (all_off) begin
      for (int i = 0; i < int'(NUM_VOICES); i++) begin
        voice_code[i] <= '0;
        voice_age[i]  <= '0;
      end
      drop <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_VOICES); i++) begin
        if (!busy[i]) begin
          voice_age[i] <= '0;
        end else if (timeout_c[i]) begin
          voice_code[i] <= '0;
          voice_age[i]  <= '0;
        end else if (voice_age[i] != '1) begin
          voice_age[i] <= voice_age[i] + TIMER_W'(1);
        end
      end
      if (wr_en_c) begin
        voice_code[wr_idx_c] <= wr_code_c;
        voice_age[wr_idx_c]  <= '0;
      end
      drop <= drop_set_c;
    end
  end

endmodule

// File: tb/tb_staff_voice_allocator.sv
// Scoreboard bench for staff_voice_allocator: timestamp-based voice model, randomized key events.
module tb_staff_voice_allocator;

  localparam int unsigned HOLD = 16;
  localparam int unsigned TW   = 5;

  typedef struct packed {
    logic [31:0] t;
    logic [31:0] codes;
    logic        drop;
    logic        ready;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       all_off = 1'b0;
  logic [7:0] scan_code1, scan_code2, scan_code3, scan_code4;
  logic [3:0] busy;
  logic       drop;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_miss = 0;
  bit         mon_en = 1'b0;
  exp_t       exp_q[$];
  exp_t       mx;

  // Model: a voice holds its code from write edge w until edge w+HOLD clears it.
  logic [7:0] m_code [4];
  int         m_wtime [4];
  bit         p_act;
  int         p_search, p_apply, p_idx;
  logic [7:0] p_code, p_wcode;
  bit         p_rel, p_wr, p_drop;

  staff_voice_if evif();

  staff_voice_allocator #(.HOLD_CYCLES(HOLD), .TIMER_W(TW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ev         (evif.slave),
    .all_off    (all_off),
    .scan_code1 (scan_code1),
    .scan_code2 (scan_code2),
    .scan_code3 (scan_code3),
    .scan_code4 (scan_code4),
    .busy       (busy),
    .drop       (drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] live(input int i, input int t);
    return (m_code[i] != 8'h00 && t < m_wtime[i] + int'(HOLD)) ? m_code[i] : 8'h00;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_code[i]  = 8'h00;
      m_wtime[i] = 0;
    end
    p_act = 1'b0;
  endtask

  // Decide the outcome of the pending event from the voices visible at time t.
  task automatic decide(input int t);
    int m, f, o;
    m = -1; f = -1; o = -1;
    for (int i = 0; i < 4; i++) begin
      if (m < 0 && live(i, t) == p_code) m = i;
      if (f < 0 && live(i, t) == 8'h00) f = i;
      if (live(i, t) != 8'h00 && (o < 0 || m_wtime[i] < m_wtime[o])) o = i;
    end
    p_wr = 1'b0; p_drop = 1'b0; p_idx = 0; p_wcode = 8'h00;
    if (p_code == 8'h00) begin
      p_wr = 1'b0;
    end else if (p_rel) begin
      if (m >= 0) begin p_wr = 1'b1; p_idx = m; end
    end else if (m >= 0) begin
      p_wr = 1'b1; p_idx = m; p_wcode = p_code;
    end else if (f >= 0) begin
      p_wr = 1'b1; p_idx = f; p_wcode = p_code;
    end else begin
`ifdef STAFF_VOICE_STEAL_EN
      p_wr = 1'b1; p_idx = o; p_wcode = p_code;
`else
      p_drop = 1'b1;
`endif
    end
  endtask

  // Drive one cycle of inputs, advance the model one edge, queue the expected outputs.
  task automatic step(input logic v, input logic [7:0] c, input logic r, input logic ao);
    int   t, e;
    bit   rdy;
    exp_t x;
    t = cyc; e = t + 1;
    evif.ev_valid = v; evif.ev_code = c; evif.ev_release = r; all_off = ao;
    rdy = !p_act;
    x = '0;
    if (ao) begin
      for (int i = 0; i < 4; i++) m_code[i] = 8'h00;
      p_act = 1'b0;
    end else begin
      if (p_act && e == p_search) begin
        decide(t);
      end else if (p_act && e == p_apply) begin
        if (p_wr) begin
          m_code[p_idx]  = p_wcode;
          m_wtime[p_idx] = e;
        end
        x.drop = p_drop;
        p_act  = 1'b0;
      end
      if (rdy && v) begin
        p_act = 1'b1; p_search = e + 1; p_apply = e + 2;
        p_code = c; p_rel = r;
      end
    end
    x.t = 32'(e);
    for (int i = 0; i < 4; i++) x.codes[8*i +: 8] = live(i, e);
    x.ready = !p_act;
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'($urandom), 1'($urandom), 1'b0);
  endtask

  // Monitor: compare DUT outputs against the queued expectation for this cycle.
  always @(negedge clk) begin
    if (mon_en && exp_q.size() > 0 && int'(exp_q[0].t) <= cyc) begin
      mx = exp_q.pop_front();
      chk("slot_time", 32'(cyc), mx.t);
      chk("scan_code1", 32'(scan_code1), 32'(mx.codes[7:0]));
      chk("scan_code2", 32'(scan_code2), 32'(mx.codes[15:8]));
      chk("scan_code3", 32'(scan_code3), 32'(mx.codes[23:16]));
      chk("scan_code4", 32'(scan_code4), 32'(mx.codes[31:24]));
      chk("busy", 32'(busy), {28'd0, mx.codes[31:24] != 8'h00, mx.codes[23:16] != 8'h00,
                               mx.codes[15:8] != 8'h00, mx.codes[7:0] != 8'h00});
      chk("drop", 32'(drop), 32'(mx.drop));
      chk("ev_ready", 32'(evif.ev_ready), 32'(mx.ready));
    end
  end

  initial begin
    evif.ev_valid = 1'b0; evif.ev_code = 8'h00; evif.ev_release = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    chk("reset_codes", {scan_code4, scan_code3, scan_code2, scan_code1}, 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_drop", 32'(drop), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(evif.ev_ready), 32'h1);
    mon_en = 1'b1;

    // Single press
    step(1'b1, 8'h52, 1'b0, 1'b0); idle(4);
    // Press, second press, retrigger, release
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h52, 1'b0, 1'b0); idle(2);
    step(1'b1, 8'h1a, 1'b0, 1'b0); idle(2);
    step(1'b1, 8'h52, 1'b0, 1'b0); idle(2);
    step(1'b1, 8'h52, 1'b1, 1'b0); idle(3);
    // Fill all four voices, then overflow
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h04, 1'b0, 1'b0); idle(2);
    step(1'b1, 8'h16, 1'b0, 1'b0); idle(2);
    step(1'b1, 8'h07, 1'b0, 1'b0); idle(2);
    step(1'b1, 8'h0a, 1'b0, 1'b0); idle(2);
    step(1'b1, 8'h0b, 1'b0, 1'b0); idle(4);
    // Auto-release, then retrigger at age 5 postponing it
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h1a, 1'b0, 1'b0); idle(HOLD + 4);
    step(1'b1, 8'h1a, 1'b0, 1'b0); idle(4);
    step(1'b1, 8'h1a, 1'b0, 1'b0); idle(HOLD + 4);
    // all_off on the SEARCH edge of a press with two voices busy
    step(1'b1, 8'h21, 1'b0, 1'b0); idle(2);
    step(1'b1, 8'h22, 1'b0, 1'b0); idle(2);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1); idle(4);
    // Code 00 press and release are no-ops
    step(1'b1, 8'h00, 1'b0, 1'b0); idle(2);
    step(1'b1, 8'h00, 1'b1, 1'b0); idle(2);

    // Randomized traffic over a small code pool
    repeat (1500) begin
      step(1'($urandom_range(0, 2) != 0),
           ($urandom_range(0, 15) == 0) ? 8'h00 : 8'(8'h10 + $urandom_range(0, 5)),
           1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 60) == 0));
    end
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    // Asynchronous reset while APPLY is in flight
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h44, 1'b0, 1'b0); idle(3);
    step(1'b1, 8'h45, 1'b0, 1'b0); idle(1);
    mon_en = 1'b0;
    exp_q.delete();
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_codes", {scan_code4, scan_code3, scan_code2, scan_code1}, 32'h0);
    chk("async_reset_busy", 32'(busy), 32'h0);
    chk("async_reset_drop", 32'(drop), 32'h0);
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_async_reset", 32'(evif.ev_ready), 32'h1);
    chk("codes_after_async_reset", {scan_code4, scan_code3, scan_code2, scan_code1}, 32'h0);
    mon_en = 1'b1;
    step(1'b1, 8'h61, 1'b0, 1'b0); idle(3);
    @(negedge clk);
    chk("final_queue_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
